// File: rtl/ni_local_port_if.sv
// Bundle of PE-side and router-side signals for the local-port network interface.
//   slave  : the NI itself (drives o_* signals, samples i_* signals)
//   master : the PE/router environment (drives i_* signals, samples o_* signals)
// Signals:
//   i_pe_data/i_pe_val, o_pe_rdy         PE -> NI injection handshake
//   o_rt_data/o_rt_data_val, i_rt_en     NI -> router local input
//   i_rt_data/i_rt_data_val, o_rt_en     router local output -> NI
//   o_pe_data/o_pe_val, i_pe_rdy         NI -> PE ejection handshake
//   o_inj_cnt/o_ej_cnt/o_stall_cnt       traffic statistics
//   o_overflow                           sticky ejection overflow flag
interface ni_local_port_if #(
  parameter int PKT_W = 32,
  parameter int CNT_W = 16
);
  logic [PKT_W-1:0] i_pe_data;
  logic             i_pe_val;
  logic             o_pe_rdy;
  logic [PKT_W-1:0] o_rt_data;
  logic             o_rt_data_val;
  logic             i_rt_en;
  logic [PKT_W-1:0] i_rt_data;
  logic             i_rt_data_val;
  logic [3:0]       o_rt_en;
  logic [PKT_W-1:0] o_pe_data;
  logic             o_pe_val;
  logic             i_pe_rdy;
  logic [CNT_W-1:0] o_inj_cnt;
  logic [CNT_W-1:0] o_ej_cnt;
  logic [CNT_W-1:0] o_stall_cnt;
  logic             o_overflow;

  modport slave (
    input  i_pe_data, i_pe_val, i_rt_en, i_rt_data, i_rt_data_val, i_pe_rdy,
    output o_pe_rdy, o_rt_data, o_rt_data_val, o_rt_en, o_pe_data, o_pe_val,
           o_inj_cnt, o_ej_cnt, o_stall_cnt, o_overflow
  );

  modport master (
    output i_pe_data, i_pe_val, i_rt_en, i_rt_data, i_rt_data_val, i_pe_rdy,
    input  o_pe_rdy, o_rt_data, o_rt_data_val, o_rt_en, o_pe_data, o_pe_val,
           o_inj_cnt, o_ej_cnt, o_stall_cnt, o_overflow
  );
endinterface

// File: rtl/ni_local_port.sv
// Network interface between a PE and the router's local port.
// Injection FIFO buffers PE packets and feeds the router, paced by i_rt_en.
// Ejection FIFO sinks router packets and advertises free space on o_rt_en.
// Ports:
//   clk    clock
//   reset  synchronous reset, active-high
//   bus    ni_local_port_if.slave (PE/router handshakes and statistics)
module ni_local_port #(
  parameter int INJ_DEPTH = 4,
  parameter int EJ_DEPTH  = 4,
  parameter int CNT_W     = 16,
  parameter int PKT_W     = 32
) (
  input logic             clk,
  input logic             reset,
  ni_local_port_if.slave  bus
);

  localparam int IA = $clog2(INJ_DEPTH);
  localparam int EA = $clog2(EJ_DEPTH);
  localparam logic [IA:0]      INJ_ONE = 1;
  localparam logic [EA:0]      EJ_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------- injection FIFO ----------------
  logic [PKT_W-1:0] inj_mem [INJ_DEPTH];
  logic [IA:0]      inj_wp, inj_rp;
  logic             inj_empty, inj_full, inj_push, inj_pop;

  assign inj_empty = (inj_wp == inj_rp);
  assign inj_full  = (inj_wp[IA] != inj_rp[IA]) && (inj_wp[IA-1:0] == inj_rp[IA-1:0]);

  // Outputs are forced inactive while reset is high so nothing leaks out
  // of FIFO contents that are about to be discarded.
  assign bus.o_pe_rdy      = !reset && !inj_full;
  assign bus.o_rt_data_val = !reset && !inj_empty && bus.i_rt_en;
  assign bus.o_rt_data     = inj_mem[inj_rp[IA-1:0]];

  assign inj_push = !reset && bus.i_pe_val && !inj_full;
  assign inj_pop  = bus.o_rt_data_val;

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wp[IA-1:0]] <= bus.i_pe_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_wp <= '0;
      inj_rp <= '0;
    end else begin
      if (inj_push) inj_wp <= inj_wp + INJ_ONE;
      if (inj_pop)  inj_rp <= inj_rp + INJ_ONE;
    end
  end

  // ---------------- ejection FIFO ----------------
  logic [PKT_W-1:0] ej_mem [EJ_DEPTH];
  logic [EA:0]      ej_wp, ej_rp;
  logic             ej_empty, ej_full, ej_push, ej_pop, ej_drop;

  assign ej_empty = (ej_wp == ej_rp);
  assign ej_full  = (ej_wp[EA] != ej_rp[EA]) && (ej_wp[EA-1:0] == ej_rp[EA-1:0]);

  // Router grant is based only on registered occupancy; a same-cycle PE pop
  // is not advertised, so the router never sees a path from i_pe_rdy.
  assign bus.o_rt_en    = reset ? 4'h0 : {4{!ej_full}};
  assign bus.o_pe_val   = !reset && !ej_empty;
  assign bus.o_pe_data  = ej_mem[ej_rp[EA-1:0]];

  assign ej_pop  = bus.o_pe_val && bus.i_pe_rdy;
  // When full, a same-cycle pop frees the slot being written (wp index == rp index).
  assign ej_push = !reset && bus.i_rt_data_val && (!ej_full || ej_pop);
  assign ej_drop = !reset && bus.i_rt_data_val && ej_full && !ej_pop;

  always_ff @(posedge clk) begin
    if (ej_push) ej_mem[ej_wp[EA-1:0]] <= bus.i_rt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ej_wp <= '0;
      ej_rp <= '0;
    end else begin
      if (ej_push) ej_wp <= ej_wp + EJ_ONE;
      if (ej_pop)  ej_rp <= ej_rp + EJ_ONE;
    end
  end

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] inj_cnt, ej_cnt, stall_cnt;
  logic             overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_cnt   <= '0;
      ej_cnt    <= '0;
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (inj_pop && inj_cnt != CNT_MAX)                      inj_cnt   <= inj_cnt + CNT_ONE;
      if (ej_push && ej_cnt != CNT_MAX)                       ej_cnt    <= ej_cnt + CNT_ONE;
      if (!inj_empty && !bus.i_rt_en && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (ej_drop)                                            overflow  <= 1'b1;
    end
  end

  assign bus.o_inj_cnt   = inj_cnt;
  assign bus.o_ej_cnt    = ej_cnt;
  assign bus.o_stall_cnt = stall_cnt;
  assign bus.o_overflow  = overflow;

endmodule

// File: tb/tb_ni_local_port.sv
module tb_ni_local_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, reset2;
  int   errors = 0;
  int   checks = 0;
  logic [15:0] inj_exp[$];
  logic [15:0] ej_exp[$];

  ni_local_port_if #(.PKT_W(16), .CNT_W(16)) bus ();
  ni_local_port_if #(.PKT_W(16), .CNT_W(4))  b2 ();

  ni_local_port #(.INJ_DEPTH(4), .EJ_DEPTH(4), .CNT_W(16), .PKT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  ni_local_port #(.INJ_DEPTH(4), .EJ_DEPTH(4), .CNT_W(4), .PKT_W(16)) dut_sat (
    .clk(clk), .reset(reset2), .bus(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares every handed-over packet against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_rt_data_val === 1'b1) begin
        if (inj_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL inj_order: unexpected packet %0h, none queued", bus.o_rt_data);
        end else chk("inj_order", {16'h0, bus.o_rt_data}, {16'h0, inj_exp.pop_front()});
      end
      if (bus.o_pe_val === 1'b1 && bus.i_pe_rdy === 1'b1) begin
        if (ej_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL ej_order: unexpected packet %0h, none queued", bus.o_pe_data);
        end else chk("ej_order", {16'h0, bus.o_pe_data}, {16'h0, ej_exp.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bus.i_pe_data = '0; bus.i_pe_val = 1'b0; bus.i_rt_en = 1'b0;
    bus.i_rt_data = '0; bus.i_rt_data_val = 1'b0; bus.i_pe_rdy = 1'b0;
    b2.i_pe_data = '0;  b2.i_pe_val = 1'b0;  b2.i_rt_en = 1'b0;
    b2.i_rt_data = '0;  b2.i_rt_data_val = 1'b0;  b2.i_pe_rdy = 1'b0;
    repeat (2) step();
    look();
    chk("rst_pe_rdy", bus.o_pe_rdy, 0);
    chk("rst_rt_en", bus.o_rt_en, 0);
    chk("rst_rt_val", bus.o_rt_data_val, 0);
    chk("rst_pe_val", bus.o_pe_val, 0);

    // 1: single packet, one-cycle presentation, no bypass
    step(); reset = 1'b0; bus.i_rt_en = 1'b1; bus.i_pe_rdy = 1'b1;
    look();
    chk("t1_pe_rdy", bus.o_pe_rdy, 1);
    chk("t1_rt_en", bus.o_rt_en, 4'hF);
    chk("t1_inj_cnt0", bus.o_inj_cnt, 0);
    step(); bus.i_pe_val = 1'b1; bus.i_pe_data = 16'hA001; inj_exp.push_back(16'hA001);
    look(); chk("t1_no_bypass", bus.o_rt_data_val, 0);
    step(); bus.i_pe_val = 1'b0;
    look(); chk("t1_val_on", bus.o_rt_data_val, 1);
    step();
    look(); chk("t1_val_off", bus.o_rt_data_val, 0);
    chk("t1_inj_cnt", bus.o_inj_cnt, 1);

    // 2: router blocked, fill to full, stall count, ordered drain
    step(); bus.i_rt_en = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.i_pe_val = 1'b1; bus.i_pe_data = 16'hB000 + 16'(k);
      look(); chk("t2_pe_rdy", bus.o_pe_rdy, (k < 4) ? 1 : 0);
      if (k < 4) inj_exp.push_back(16'hB000 + 16'(k));
      step();
    end
    bus.i_pe_val = 1'b0; bus.i_rt_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      look(); chk("t2_drain_val", bus.o_rt_data_val, 1);
      if (j == 0) chk("t2_stall_cnt", bus.o_stall_cnt, 5);
      step();
    end
    look(); chk("t2_drain_done", bus.o_rt_data_val, 0);
    step(); bus.i_pe_val = 1'b1; bus.i_pe_data = 16'hB004; inj_exp.push_back(16'hB004);
    step(); bus.i_pe_data = 16'hB005; inj_exp.push_back(16'hB005);
    step(); bus.i_pe_val = 1'b0;
    step(); step();
    look();
    chk("t2_inj_cnt", bus.o_inj_cnt, 7);
    chk("t2_stall_hold", bus.o_stall_cnt, 5);

    // 3: ejection fill, forced overflow, ordered drain
    step(); bus.i_pe_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_rt_data_val = 1'b1; bus.i_rt_data = 16'hC000 + 16'(k);
      ej_exp.push_back(16'hC000 + 16'(k));
      look(); chk("t3_rt_en", bus.o_rt_en, 4'hF);
      step();
    end
    bus.i_rt_data = 16'hC004;
    look();
    chk("t3_rt_en_full", bus.o_rt_en, 4'h0);
    chk("t3_ovf_before", bus.o_overflow, 0);
    step(); bus.i_rt_data_val = 1'b0;
    look();
    chk("t3_overflow", bus.o_overflow, 1);
    chk("t3_ej_cnt", bus.o_ej_cnt, 4);
    step(); bus.i_pe_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      look(); chk("t3_drain_val", bus.o_pe_val, 1);
      step();
    end
    look();
    chk("t3_drain_done", bus.o_pe_val, 0);
    chk("t3_rt_en_free", bus.o_rt_en, 4'hF);

    // 5: reset with traffic queued on both sides
    step(); bus.i_rt_en = 1'b0; bus.i_pe_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_pe_val = 1'b1; bus.i_pe_data = 16'hD000 + 16'(k);
      bus.i_rt_data_val = 1'b1; bus.i_rt_data = 16'hE000 + 16'(k);
      step();
    end
    bus.i_pe_val = 1'b0; bus.i_rt_data_val = 1'b0;
    look(); chk("t5_queued", bus.o_pe_val, 1);
    step(); reset = 1'b1; bus.i_rt_en = 1'b1; bus.i_pe_rdy = 1'b1;
    look();
    chk("t5_rst_rt_val", bus.o_rt_data_val, 0);
    chk("t5_rst_pe_val", bus.o_pe_val, 0);
    chk("t5_rst_pe_rdy", bus.o_pe_rdy, 0);
    chk("t5_rst_rt_en", bus.o_rt_en, 4'h0);
    step();
    look();
    chk("t5_inj_cnt", bus.o_inj_cnt, 0);
    chk("t5_ej_cnt", bus.o_ej_cnt, 0);
    chk("t5_stall_cnt", bus.o_stall_cnt, 0);
    chk("t5_overflow", bus.o_overflow, 0);
    step(); reset = 1'b0;
    look();
    chk("t5_pe_rdy", bus.o_pe_rdy, 1);
    chk("t5_rt_en", bus.o_rt_en, 4'hF);
    chk("t5_rt_val_empty", bus.o_rt_data_val, 0);
    chk("t5_pe_val_empty", bus.o_pe_val, 0);

    // 4: full ejection FIFO with same-cycle pop and push
    step(); bus.i_pe_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.i_rt_data_val = 1'b1; bus.i_rt_data = 16'hF000 + 16'(k);
      ej_exp.push_back(16'hF000 + 16'(k));
      step();
    end
    bus.i_rt_data = 16'hF004; bus.i_pe_rdy = 1'b1; ej_exp.push_back(16'hF004);
    look(); chk("t4_rt_en_full", bus.o_rt_en, 4'h0);
    step(); bus.i_rt_data_val = 1'b0; bus.i_pe_rdy = 1'b0;
    look();
    chk("t4_no_overflow", bus.o_overflow, 0);
    chk("t4_still_full", bus.o_rt_en, 4'h0);
    chk("t4_ej_cnt", bus.o_ej_cnt, 5);
    step(); bus.i_pe_rdy = 1'b1;
    for (int j = 0; j < 4; j++) begin
      look(); chk("t4_drain_val", bus.o_pe_val, 1);
      step();
    end
    look(); chk("t4_drain_done", bus.o_pe_val, 0);

    // 6: saturating counter on the CNT_W=4 instance
    step(); reset2 = 1'b0; b2.i_rt_en = 1'b1; b2.i_pe_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      b2.i_pe_val = 1'b1; b2.i_pe_data = 16'(k);
      step();
    end
    b2.i_pe_val = 1'b0;
    step(); step();
    look();
    chk("t6_inj_sat", b2.o_inj_cnt, 4'hF);
    chk("t6_pe_rdy", b2.o_pe_rdy, 1);

    chk("inj_queue_empty", inj_exp.size(), 0);
    chk("ej_queue_empty", ej_exp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
